// File: rtl/cic_pkg.sv
// Shared constants, FSM encoding and the integer log helper for the CIC gain shifter.
package cic_pkg;

  localparam int CIC_BW = 16;
  localparam int CIC_N  = 4;
  localparam int CIC_RW = 8;

  typedef enum logic [1:0] {
    START = 2'd0,
    POWER = 2'd1,
    LOG   = 2'd2,
    IDLE  = 2'd3
  } gain_state_t;

  // Smallest g with x <= 2**g (so 0 and 1 both give 0); x is at most 64 bits.
  function automatic logic [31:0] cic_clog2(input logic [63:0] x);
    logic [31:0] g;
    g = '0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < x) g = 32'(i + 1);
    end
    return g;
  endfunction

endpackage

// File: rtl/cic_dec_gain_shifter_if.sv
// Sample/rate bus between the last comb stage, the gain shifter and the output stage.
interface cic_dec_gain_shifter_if
  import cic_pkg::*;
#(
  parameter int BW         = CIC_BW,
  parameter int RW         = CIC_RW,
  parameter int MAXBITGAIN = CIC_N * CIC_RW
);
  logic [RW-1:0]                  rate;
  logic                           strobe_in;
  logic signed [BW+MAXBITGAIN-1:0] signal_in;
  logic                           strobe_out;
  logic signed [BW-1:0]           signal_out;
  logic                           sat;
  logic                           gain_ready;

  modport master (
    output rate, strobe_in, signal_in,
    input  strobe_out, signal_out, sat, gain_ready
  );

  modport slave (
    input  rate, strobe_in, signal_in,
    output strobe_out, signal_out, sat, gain_ready
  );
endinterface

// File: rtl/cic_bitgain_calc.sv
// Multi-cycle engine computing ceil(N*log2(rate)) as rate**N followed by an integer clog2.
module cic_bitgain_calc
  import cic_pkg::*;
#(
  parameter int N          = CIC_N,
  parameter int RW         = CIC_RW,
  parameter int MAXBITGAIN = N * RW,
  parameter int SW         = $clog2(MAXBITGAIN + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [RW-1:0] rate,
  output logic [SW-1:0] shift,
  output logic          gain_ready
);

  localparam int AW = N * RW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  gain_state_t   state_reg, state_next;
  logic [RW-1:0] rate_q_reg, rate_q_next;
  logic [AW-1:0] acc_reg, acc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [SW-1:0] shift_reg, shift_next;
  logic          ready_reg, ready_next;
  logic [31:0]   lg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= START;
      rate_q_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      shift_reg  <= SW'(MAXBITGAIN);
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rate_q_reg <= rate_q_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      ready_reg  <= ready_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rate_q_next = rate_q_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    ready_next  = ready_reg;
    lg          = cic_clog2(64'(acc_reg));
    unique case (state_reg)
      START: begin
        rate_q_next = rate;
        acc_next    = AW'(rate);
        cnt_next    = CW'(N - 1);
        state_next  = (N == 1) ? LOG : POWER;
      end
      POWER: begin
        if (rate != rate_q_reg) begin
          state_next = START;
        end else begin
          acc_next = acc_reg * AW'(rate_q_reg);
          cnt_next = cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) state_next = LOG;
        end
      end
      LOG: begin
        // A rate change here restarts without touching shift, so no stale gain is published.
        if (rate != rate_q_reg) begin
          state_next = START;
        end else begin
          if (rate_q_reg == '0)
            shift_next = SW'(MAXBITGAIN);
          else
            shift_next = (lg > 32'(MAXBITGAIN)) ? SW'(MAXBITGAIN) : SW'(lg);
          ready_next = 1'b1;
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (rate != rate_q_reg) begin
          ready_next = 1'b0;
          state_next = START;
        end
      end
      default: state_next = START;
    endcase
  end

  assign shift      = shift_reg;
  assign gain_ready = ready_reg;

endmodule

// File: rtl/cic_dec_gain_shifter.sv
// Two-stage output shifter for an N-stage CIC decimator: round half-up, then saturate to BW bits.
module cic_dec_gain_shifter
  import cic_pkg::*;
#(
  parameter int BW         = CIC_BW,
  parameter int N          = CIC_N,
  parameter int RW         = CIC_RW,
  parameter int MAXBITGAIN = N * RW
) (
  input  logic                  clock,
  input  logic                  reset_n,
  cic_dec_gain_shifter_if.slave bus
);

  localparam int IW = BW + MAXBITGAIN;
  localparam int XW = IW + 1;
  localparam int SW = $clog2(MAXBITGAIN + 1);
  localparam logic signed [XW-1:0] SAT_HI = {{(XW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_LO = {{(XW-BW+1){1'b1}}, {(BW-1){1'b0}}};

  logic [SW-1:0]          shift;
  logic                   gain_ready;
  logic signed [XW-1:0]   sig_ext;
  logic signed [XW-1:0]   shifted;
  logic signed [XW-1:0]   t_next;
  logic signed [XW-1:0]   t_reg;
  logic [XW-1:0]          round_mask;
  logic                   rnd_bit;
  logic                   v1_reg;
  logic                   clip_hi, clip_lo;
  logic [BW-1:0]          sat_val;
  logic                   strobe_out_reg;
  logic [BW-1:0]          signal_out_reg;
  logic                   sat_reg;

  cic_bitgain_calc #(
    .N          (N),
    .RW         (RW),
    .MAXBITGAIN (MAXBITGAIN),
    .SW         (SW)
  ) u_bitgain (
    .clock      (clock),
    .reset_n    (reset_n),
    .rate       (bus.rate),
    .shift      (shift),
    .gain_ready (gain_ready)
  );

  // One extra sign bit keeps the rounding increment from overflowing.
  assign sig_ext = {bus.signal_in[IW-1], bus.signal_in};
  assign shifted = sig_ext >>> shift;

  // Selects bit shift-1, the half-LSB that decides round-up; all zero when shift is 0.
  genvar gi;
  generate
    for (gi = 0; gi < XW; gi++) begin : g_round
      assign round_mask[gi] = (32'(shift) == 32'(gi + 1));
    end
  endgenerate

  assign rnd_bit = |(sig_ext & round_mask);
  assign t_next  = shifted + {{(XW-1){1'b0}}, rnd_bit};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_reg <= 1'b0;
      t_reg  <= '0;
    end else begin
      v1_reg <= bus.strobe_in;
      if (bus.strobe_in) t_reg <= t_next;
    end
  end

  always_comb begin
    clip_hi = (t_reg > SAT_HI);
    clip_lo = (t_reg < SAT_LO);
    sat_val = t_reg[BW-1:0];
    if (clip_hi)
      sat_val = {1'b0, {(BW-1){1'b1}}};
    else if (clip_lo)
      sat_val = {1'b1, {(BW-1){1'b0}}};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_out_reg <= 1'b0;
      signal_out_reg <= '0;
      sat_reg        <= 1'b0;
    end else begin
      strobe_out_reg <= v1_reg;
      sat_reg        <= v1_reg & (clip_hi | clip_lo);
      if (v1_reg) signal_out_reg <= sat_val;
    end
  end

  assign bus.strobe_out = strobe_out_reg;
  assign bus.signal_out = signal_out_reg;
  assign bus.sat        = sat_reg;
  assign bus.gain_ready = gain_ready;

endmodule

// File: tb/tb_cic_dec_gain_shifter.sv
// Randomised bench for cic_dec_gain_shifter against an arithmetic model of rounding, saturation and CIC gain.
module tb_cic_dec_gain_shifter;

  localparam int BW  = 16;
  localparam int N   = 4;
  localparam int RW  = 8;
  localparam int MBG = N * RW;
  localparam int IW  = BW + MBG;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  int out_val_q[$];
  bit out_sat_q[$];

  cic_dec_gain_shifter_if #(.BW(BW), .RW(RW), .MAXBITGAIN(MBG)) bus ();

  cic_dec_gain_shifter #(.BW(BW), .N(N), .RW(RW), .MAXBITGAIN(MBG)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.strobe_out === 1'b1) begin
      out_val_q.push_back(int'(bus.signal_out));
      out_sat_q.push_back(bus.sat);
    end
  end

  // ceil(N*log2(rate)) as the smallest g with rate**N <= 2**g; rate 0 means full gain.
  function automatic int exp_shift(input int r);
    longint p;
    int g;
    if (r == 0) return MBG;
    p = 1;
    for (int k = 0; k < N; k++) p = p * r;
    g = 0;
    while ((longint'(1) << g) < p) g++;
    return (g > MBG) ? MBG : g;
  endfunction

  // floor(x/2^s + 1/2), then clip to the signed BW-bit range.
  function automatic void model_out(input longint x, input int s, output int y, output bit c);
    longint t;
    t = (s == 0) ? x : ((x + (longint'(1) << (s - 1))) >>> s);
    c = 1'b0;
    if (t > 32767) begin
      t = 32767; c = 1'b1;
    end else if (t < -32768) begin
      t = -32768; c = 1'b1;
    end
    y = int'(t);
  endfunction

  function automatic longint rand_wide();
    return longint'($signed($urandom)) >>> 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.gain_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    longint x;
    bus.rate = 8'd128; bus.strobe_in = 1'b0; bus.signal_in = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    vectors += 4;
    if (bus.strobe_out !== 1'b0) begin miscompares++; $display("FAIL reset_strobe_out: got %b required 0", bus.strobe_out); end
    if (bus.signal_out !== '0) begin miscompares++; $display("FAIL reset_signal_out: got %0d required 0", bus.signal_out); end
    if (bus.sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b required 0", bus.sat); end
    if (bus.gain_ready !== 1'b0) begin miscompares++; $display("FAIL reset_gain_ready: got %b required 0", bus.gain_ready); end
    reset_n = 1'b1;
    repeat (4) tick();
    vectors++;
    if (bus.gain_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_early: got %b required 0", bus.gain_ready); end
    tick();
    vectors++;
    if (bus.gain_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_rise: got %b required 1", bus.gain_ready); end
    x = longint'(1000) << 28;
    bus.strobe_in = 1'b1; bus.signal_in = IW'(x);
    tick();
    bus.strobe_in = 1'b0;
    vectors++;
    if (bus.strobe_out !== 1'b0) begin miscompares++; $display("FAIL reset_latency_c1: strobe_out %b required 0", bus.strobe_out); end
    tick();
    vectors += 3;
    if (bus.strobe_out !== 1'b1) begin miscompares++; $display("FAIL reset_latency_c2: strobe_out %b required 1", bus.strobe_out); end
    if (int'(bus.signal_out) !== 1000) begin miscompares++; $display("FAIL reset_first_sample: got %0d required 1000", bus.signal_out); end
    if (bus.sat !== 1'b0) begin miscompares++; $display("FAIL reset_first_sat: got %b required 0", bus.sat); end
    repeat (2) tick();
    out_val_q.delete(); out_sat_q.delete();
    $display("test_reset done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  task automatic test_rounding_saturation();
    bit ok;
    longint xs[$];
    int ev[$];
    bit es[$];
    longint tab_x[7] = '{24, -24, 23, 'h7FFF8, -'h80000, -'h80009, 'h7FFF7};
    int     tab_y[7] = '{2, -1, 1, 32767, -32768, -32768, 32767};
    bit     tab_c[7] = '{0, 0, 0, 1, 0, 1, 0};
    int y; bit c; longint x;
    bus.rate = 8'd2;
    repeat (2) tick();
    wait_ready(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL round_settle: gain_ready %b required 1", bus.gain_ready); end
    out_val_q.delete(); out_sat_q.delete();
    for (int i = 0; i < 13; i++) begin
      if (i < 7) begin
        x = tab_x[i]; ev.push_back(tab_y[i]); es.push_back(tab_c[i]);
      end else begin
        x = longint'($urandom_range(0, 1200000)) - 600000;
        model_out(x, 4, y, c); ev.push_back(y); es.push_back(c);
      end
      xs.push_back(x);
      bus.strobe_in = 1'b1; bus.signal_in = IW'(x);
      tick();
    end
    bus.strobe_in = 1'b0;
    repeat (3) tick();
    vectors++;
    if (out_val_q.size() != ev.size()) begin miscompares++; $display("FAIL round_count: got %0d samples required %0d", out_val_q.size(), ev.size()); end
    for (int i = 0; i < ev.size() && i < out_val_q.size(); i++) begin
      vectors++;
      if (out_val_q[i] !== ev[i] || out_sat_q[i] !== es[i]) begin
        miscompares++;
        $display("FAIL round_sat[%0d] in=%0d: got %0d sat=%0b required %0d sat=%0b", i, xs[i], out_val_q[i], out_sat_q[i], ev[i], es[i]);
      end
    end
    $display("test_rounding_saturation done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  task automatic test_gain_sweep();
    bit ok; int r, s, y; bit c; longint x;
    for (int idx = 0; idx < 256; idx++) begin
      r = (idx == 255) ? 0 : idx + 1;
      s = exp_shift(r);
      bus.rate = RW'(r);
      repeat (2) tick();
      wait_ready(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL sweep_settle rate=%0d: gain_ready %b required 1", r, bus.gain_ready); end
      x = (longint'($urandom_range(0, 40000)) - 20000) * (longint'(1) << s);
      if (s > 0) x = x + (longint'($urandom) & ((longint'(1) << s) - 1));
      model_out(x, s, y, c);
      out_val_q.delete(); out_sat_q.delete();
      bus.strobe_in = 1'b1; bus.signal_in = IW'(x);
      tick();
      bus.strobe_in = 1'b0;
      repeat (2) tick();
      vectors++;
      if (out_val_q.size() != 1 || out_val_q[0] !== y || out_sat_q[0] !== c) begin
        miscompares++;
        $display("FAIL sweep rate=%0d shift=%0d in=%0d: got n=%0d val=%0d required %0d sat=%0b",
                 r, s, x, out_val_q.size(), (out_val_q.size() > 0) ? out_val_q[0] : 0, y, c);
      end
    end
    $display("test_gain_sweep done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  // Stream continuously while the rate changes; r2 >= 0 requests a second change at cycle 2.
  task automatic test_stream_change(input string name, input int r1, input int r2, input int new_shift, input int switch_cycle);
    bit ok; bit exp_rdy;
    longint xs[$]; int shs[$];
    int y; bit c; longint x;
    bus.rate = 8'd16;
    repeat (2) tick();
    wait_ready(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL %s_settle: gain_ready %b required 1", name, bus.gain_ready); end
    out_val_q.delete(); out_sat_q.delete();
    for (int j = 0; j < switch_cycle + 6; j++) begin
      if (j == 0) bus.rate = RW'(r1);
      if (j == 2 && r2 >= 0) bus.rate = RW'(r2);
      x = rand_wide();
      xs.push_back(x);
      shs.push_back((j < switch_cycle) ? 16 : new_shift);
      bus.strobe_in = 1'b1; bus.signal_in = IW'(x);
      exp_rdy = (j == 0) || (j >= switch_cycle);
      vectors++;
      if (bus.gain_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL %s_ready cycle %0d: got %b required %b", name, j, bus.gain_ready, exp_rdy);
      end
      tick();
    end
    bus.strobe_in = 1'b0;
    repeat (3) tick();
    vectors++;
    if (out_val_q.size() != xs.size()) begin miscompares++; $display("FAIL %s_count: got %0d samples required %0d", name, out_val_q.size(), xs.size()); end
    for (int i = 0; i < xs.size() && i < out_val_q.size(); i++) begin
      model_out(xs[i], shs[i], y, c);
      vectors++;
      if (out_val_q[i] !== y || out_sat_q[i] !== c) begin
        miscompares++;
        $display("FAIL %s[%0d] shift=%0d in=%0d: got %0d sat=%0b required %0d sat=%0b", name, i, shs[i], xs[i], out_val_q[i], out_sat_q[i], y, c);
      end
    end
    $display("test %s done: vectors=%0d miscompares=%0d", name, vectors, miscompares);
  endtask

  task automatic test_reset_midpipe();
    bit ok;
    longint x;
    x = longint'(1234) << 20;
    out_val_q.delete(); out_sat_q.delete();
    bus.strobe_in = 1'b1; bus.signal_in = IW'(x);
    tick();
    bus.signal_in = IW'(-x);
    tick();
    bus.strobe_in = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    vectors += 4;
    if (bus.strobe_out !== 1'b0) begin miscompares++; $display("FAIL midreset_strobe: got %b required 0", bus.strobe_out); end
    if (bus.signal_out !== '0) begin miscompares++; $display("FAIL midreset_signal: got %0d required 0", bus.signal_out); end
    if (bus.sat !== 1'b0) begin miscompares++; $display("FAIL midreset_sat: got %b required 0", bus.sat); end
    if (bus.gain_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready: got %b required 0", bus.gain_ready); end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if (out_val_q.size() != 0) begin miscompares++; $display("FAIL midreset_discard: got %0d samples required 0", out_val_q.size()); end
    wait_ready(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL midreset_settle: gain_ready %b required 1", bus.gain_ready); end
    bus.strobe_in = 1'b1; bus.signal_in = IW'(x);
    tick();
    bus.strobe_in = 1'b0;
    repeat (2) tick();
    vectors++;
    if (out_val_q.size() != 1 || out_val_q[0] !== 1234) begin
      miscompares++;
      $display("FAIL midreset_resume: got n=%0d val=%0d required 1234", out_val_q.size(), (out_val_q.size() > 0) ? out_val_q[0] : 0);
    end
    $display("test_reset_midpipe done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  initial begin
    test_reset();
    test_rounding_saturation();
    test_gain_sweep();
    test_stream_change("rate_change", 64, -1, 24, 6);
    test_stream_change("abort", 64, 32, 20, 8);
    test_reset_midpipe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
